ucode_sequencer: RTL and testbench

Parametrised, table-driven micro-step sequencer that sits between the instruction register and the control-signal decoder. Per opcode, a programmable entry gives the base control-state code and step count. A zero-conditional alternate path is selected once per instruction. The block issues one control-state code per enabled clock, requests the next IR source, and flags halt and illegal opcodes.

---
 rtl/ucode_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_ucode_sequencer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/ucode_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : ucode_sequencer
// Description : Table-driven micro-step sequencer; per-opcode programmable
//               base/length with a zero-conditional alternate path.
// Revision    : 1.0 - initial release
// ============================================================================
module ucode_sequencer #(
    parameter int unsigned OP_W     = 6,
    parameter int unsigned SIG_W    = 6,
    parameter int unsigned STEP_W   = 3,
    parameter int unsigned FETCH_OP = 1,
    parameter int unsigned HALT_OP  = 57,
    parameter int unsigned NOP_SIG  = 56
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start,
    input  logic [OP_W-1:0]                 ir_out,
    input  logic                            z_in,
    input  logic                            cfg_we,
    input  logic [OP_W-1:0]                 cfg_addr,
    input  logic [2*SIG_W+2*STEP_W+1-1:0]   cfg_data,
    output logic [SIG_W-1:0]                sm_sig,
    output logic [OP_W-1:0]                 ir_next,
    output logic                            instr_done,
    output logic                            illegal,
    output logic                            halted
);

    localparam int unsigned c_CFG_W = 2*SIG_W + 2*STEP_W + 1;
    localparam int unsigned c_DEPTH = 1 << OP_W;

    localparam logic [OP_W-1:0]    c_FETCH_OP = OP_W'(FETCH_OP);
    localparam logic [OP_W-1:0]    c_HALT_OP  = OP_W'(HALT_OP);
    localparam logic [SIG_W-1:0]   c_NOP_SIG  = SIG_W'(NOP_SIG);
    localparam logic [STEP_W-1:0]  c_STEP_ONE = STEP_W'(1);
    localparam logic [c_CFG_W-1:0] c_FETCH_ENTRY =
        {1'b0, STEP_W'(0), SIG_W'(0), STEP_W'(3), SIG_W'(1)};

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [STEP_W-1:0]   step_q, step_d;
    logic [OP_W-1:0]     cur_op_q, cur_op_d;
    logic [SIG_W-1:0]    sel_base_q, sel_base_d;
    logic [STEP_W-1:0]   sel_len_q, sel_len_d;
    logic [SIG_W-1:0]    sm_sig_q, sm_sig_d;
    logic [OP_W-1:0]     ir_next_q, ir_next_d;
    logic                instr_done_q, instr_done_d;
    logic                illegal_q, illegal_d;
    logic                halted_q, halted_d;

    logic [c_CFG_W-1:0]  table_q [c_DEPTH];

    logic [c_CFG_W-1:0]  w_entry;
    logic [SIG_W-1:0]    w_sel_base;
    logic [STEP_W-1:0]   w_sel_len;
    logic                w_use_z;

    // Table resets to its boot contents so a reset always re-enters a sane fetch loop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < c_DEPTH; i++) begin
                table_q[i] <= (i == FETCH_OP) ? c_FETCH_ENTRY : '0;
            end
        end else if (cfg_we) begin
            table_q[cfg_addr] <= cfg_data;
        end
    end

    assign w_entry    = table_q[ir_out];
    assign w_use_z    = w_entry[2*SIG_W+2*STEP_W] & z_in;
    assign w_sel_base = w_use_z ? w_entry[SIG_W+STEP_W +: SIG_W]
                                : w_entry[0 +: SIG_W];
    assign w_sel_len  = w_use_z ? w_entry[2*SIG_W+STEP_W +: STEP_W]
                                : w_entry[SIG_W +: STEP_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_RUN;
            step_q       <= '0;
            cur_op_q     <= '0;
            sel_base_q   <= '0;
            sel_len_q    <= '0;
            sm_sig_q     <= c_NOP_SIG;
            ir_next_q    <= c_FETCH_OP;
            instr_done_q <= 1'b0;
            illegal_q    <= 1'b0;
            halted_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            step_q       <= step_d;
            cur_op_q     <= cur_op_d;
            sel_base_q   <= sel_base_d;
            sel_len_q    <= sel_len_d;
            sm_sig_q     <= sm_sig_d;
            ir_next_q    <= ir_next_d;
            instr_done_q <= instr_done_d;
            illegal_q    <= illegal_d;
            halted_q     <= halted_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        step_d       = step_q;
        cur_op_d     = cur_op_q;
        sel_base_d   = sel_base_q;
        sel_len_d    = sel_len_q;
        sm_sig_d     = sm_sig_q;
        ir_next_d    = ir_next_q;
        instr_done_d = 1'b0;
        illegal_d    = 1'b0;
        halted_d     = halted_q;

        case (state_q)
            ST_RUN: begin
                if (start) begin
                    if (step_q == '0) begin
                        if (ir_out == c_HALT_OP) begin
                            sm_sig_d = c_NOP_SIG;
                            halted_d = 1'b1;
                            state_d  = ST_HALT;
                        end else if (w_sel_len == '0) begin
                            sm_sig_d  = c_NOP_SIG;
                            illegal_d = 1'b1;
                            ir_next_d = c_FETCH_OP;
                        end else begin
                            cur_op_d   = ir_out;
                            sel_base_d = w_sel_base;
                            sel_len_d  = w_sel_len;
                            sm_sig_d   = w_sel_base;
                            if (w_sel_len == c_STEP_ONE) begin
                                instr_done_d = 1'b1;
                                if (ir_out != c_FETCH_OP) begin
                                    ir_next_d = c_FETCH_OP;
                                end
                            end else begin
                                step_d = c_STEP_ONE;
                            end
                            // Fetch hands the IR back to memory on its first step.
                            if (ir_out == c_FETCH_OP) begin
                                ir_next_d = '0;
                            end
                        end
                    end else begin
                        sm_sig_d = sel_base_q + SIG_W'(step_q);
                        if (step_q == sel_len_q - c_STEP_ONE) begin
                            instr_done_d = 1'b1;
                            step_d       = '0;
                            if (cur_op_q != c_FETCH_OP) begin
                                ir_next_d = c_FETCH_OP;
                            end
                        end else begin
                            step_d = step_q + c_STEP_ONE;
                        end
                    end
                end
            end
            ST_HALT: begin
                sm_sig_d = c_NOP_SIG;
                halted_d = 1'b1;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    assign sm_sig     = sm_sig_q;
    assign ir_next    = ir_next_q;
    assign instr_done = instr_done_q;
    assign illegal    = illegal_q;
    assign halted     = halted_q;

endmodule
`default_nettype wire

// File: tb/tb_ucode_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_ucode_sequencer
// Description : Directed, table-driven self-checking bench for ucode_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ucode_sequencer;

    localparam int unsigned c_OP_W   = 6;
    localparam int unsigned c_SIG_W  = 6;
    localparam int unsigned c_STEP_W = 3;
    localparam int unsigned c_CFG_W  = 2*c_SIG_W + 2*c_STEP_W + 1;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                start = 1'b0;
    logic [c_OP_W-1:0]   ir_out = '0;
    logic                z_in = 1'b0;
    logic                cfg_we = 1'b0;
    logic [c_OP_W-1:0]   cfg_addr = '0;
    logic [c_CFG_W-1:0]  cfg_data = '0;
    logic [c_SIG_W-1:0]  sm_sig;
    logic [c_OP_W-1:0]   ir_next;
    logic                instr_done;
    logic                illegal;
    logic                halted;

    int n_cmp = 0;
    int n_bad = 0;

    ucode_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .ir_out     (ir_out),
        .z_in       (z_in),
        .cfg_we     (cfg_we),
        .cfg_addr   (cfg_addr),
        .cfg_data   (cfg_data),
        .sm_sig     (sm_sig),
        .ir_next    (ir_next),
        .instr_done (instr_done),
        .illegal    (illegal),
        .halted     (halted)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic               start;
        int unsigned        ir;
        logic               z;
        logic               we;
        int unsigned        addr;
        logic [c_CFG_W-1:0] data;
        int unsigned        e_sig;
        int unsigned        e_nx;
        logic               e_done;
        logic               e_ill;
        logic               e_halt;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [c_CFG_W-1:0] mk(input int unsigned cond, input int unsigned zlen,
                                              input int unsigned zbase, input int unsigned len,
                                              input int unsigned base);
        return {cond[0], zlen[c_STEP_W-1:0], zbase[c_SIG_W-1:0], len[c_STEP_W-1:0], base[c_SIG_W-1:0]};
    endfunction

    function automatic void add(input logic s, input int unsigned ir, input logic z,
                                input logic we, input int unsigned addr, input logic [c_CFG_W-1:0] data,
                                input int unsigned e_sig, input int unsigned e_nx,
                                input logic e_done, input logic e_ill, input logic e_halt);
        vec_t v;
        v.start = s; v.ir = ir; v.z = z; v.we = we; v.addr = addr; v.data = data;
        v.e_sig = e_sig; v.e_nx = e_nx; v.e_done = e_done; v.e_ill = e_ill; v.e_halt = e_halt;
        vecs.push_back(v);
    endfunction

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_outs(input string tag, input int unsigned e_sig, input int unsigned e_nx,
                            input logic e_done, input logic e_ill, input logic e_halt);
        chk({tag, ".sm_sig"},     sm_sig,     e_sig);
        chk({tag, ".ir_next"},    ir_next,    e_nx);
        chk({tag, ".instr_done"}, instr_done, e_done);
        chk({tag, ".illegal"},    illegal,    e_ill);
        chk({tag, ".halted"},     halted,     e_halt);
    endtask

    task automatic drive(input logic s, input int unsigned ir, input logic z,
                         input logic we, input int unsigned addr, input logic [c_CFG_W-1:0] data);
        @(negedge clk);
        start    = s;
        ir_out   = ir[c_OP_W-1:0];
        z_in     = z;
        cfg_we   = we;
        cfg_addr = addr[c_OP_W-1:0];
        cfg_data = data;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // {start, ir, z, we, addr, data} -> {sm_sig, ir_next, done, illegal, halted}
        add(1,  1, 0, 0, 0, '0,             1, 0, 0, 0, 0);
        add(1,  1, 0, 0, 0, '0,             2, 0, 0, 0, 0);
        add(1,  1, 0, 0, 0, '0,             3, 0, 1, 0, 0);
        add(0,  1, 0, 1, 4, mk(0,0,0,4,4),  3, 0, 0, 0, 0);
        add(0,  1, 0, 1, 52, mk(1,2,54,4,52), 3, 0, 0, 0, 0);
        add(1,  4, 0, 0, 0, '0,             4, 0, 0, 0, 0);
        add(1,  4, 0, 0, 0, '0,             5, 0, 0, 0, 0);
        add(1,  8, 0, 0, 0, '0,             6, 0, 0, 0, 0);
        add(1,  8, 0, 0, 0, '0,             7, 1, 1, 0, 0);
        add(1, 52, 0, 0, 0, '0,            52, 1, 0, 0, 0);
        add(1, 52, 1, 0, 0, '0,            53, 1, 0, 0, 0);
        add(1, 52, 0, 0, 0, '0,            54, 1, 0, 0, 0);
        add(1, 52, 1, 0, 0, '0,            55, 1, 1, 0, 0);
        add(1, 52, 1, 0, 0, '0,            54, 1, 0, 0, 0);
        add(1, 52, 0, 0, 0, '0,            55, 1, 1, 0, 0);
        add(1,  9, 0, 0, 0, '0,            56, 1, 0, 1, 0);
        add(1,  1, 0, 0, 0, '0,             1, 0, 0, 0, 0);
        add(1,  1, 0, 0, 0, '0,             2, 0, 0, 0, 0);
        add(1,  1, 0, 0, 0, '0,             3, 0, 1, 0, 0);
        add(1,  4, 0, 0, 0, '0,             4, 0, 0, 0, 0);
        add(1,  4, 0, 0, 0, '0,             5, 0, 0, 0, 0);
        add(0,  9, 0, 0, 0, '0,             5, 0, 0, 0, 0);
        add(0, 57, 0, 0, 0, '0,             5, 0, 0, 0, 0);
        add(0,  4, 0, 0, 0, '0,             5, 0, 0, 0, 0);
        add(1,  8, 0, 0, 0, '0,             6, 0, 0, 0, 0);
        add(1,  8, 0, 0, 0, '0,             7, 1, 1, 0, 0);
        add(1,  4, 0, 0, 0, '0,             4, 1, 0, 0, 0);
        add(1,  4, 0, 1, 4, mk(0,0,0,2,4),  5, 1, 0, 0, 0);
        add(1,  4, 0, 0, 0, '0,             6, 1, 0, 0, 0);
        add(1,  4, 0, 0, 0, '0,             7, 1, 1, 0, 0);
        add(1,  4, 0, 1, 4, mk(0,0,0,3,4),  4, 1, 0, 0, 0);
        add(1,  4, 0, 0, 0, '0,             5, 1, 1, 0, 0);
        add(1,  4, 1, 0, 0, '0,             4, 1, 0, 0, 0);
        add(1,  4, 0, 0, 0, '0,             5, 1, 0, 0, 0);
        add(1,  4, 0, 0, 0, '0,             6, 1, 1, 0, 0);
        add(0,  4, 0, 1, 5, mk(0,0,0,1,20), 6, 1, 0, 0, 0);
        add(1,  5, 0, 0, 0, '0,            20, 1, 1, 0, 0);
        add(1,  5, 0, 0, 0, '0,            20, 1, 1, 0, 0);
        add(0,  5, 0, 1, 6, mk(0,0,0,3,62), 20, 1, 0, 0, 0);
        add(1,  6, 0, 0, 0, '0,            62, 1, 0, 0, 0);
        add(1,  6, 0, 0, 0, '0,            63, 1, 0, 0, 0);
        add(1,  6, 0, 0, 0, '0,             0, 1, 1, 0, 0);
        add(0,  6, 0, 1, 7, mk(1,0,30,2,10), 0, 1, 0, 0, 0);
        add(1,  7, 1, 0, 0, '0,            56, 1, 0, 1, 0);
        add(1,  7, 0, 0, 0, '0,            10, 1, 0, 0, 0);
        add(1,  7, 0, 0, 0, '0,            11, 1, 1, 0, 0);

        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_outs("reset", 56, 1, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].start, vecs[i].ir, vecs[i].z, vecs[i].we, vecs[i].addr, vecs[i].data);
            chk_outs($sformatf("vec%0d", i), vecs[i].e_sig, vecs[i].e_nx,
                     vecs[i].e_done, vecs[i].e_ill, vecs[i].e_halt);
        end

        // Reset mid-instruction: outputs drop at once, table returns to boot contents.
        drive(1, 4, 0, 0, 0, '0);
        chk_outs("mid.s0", 4, 1, 0, 0, 0);
        drive(1, 4, 0, 0, 0, '0);
        chk_outs("mid.s1", 5, 1, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_outs("async_rst", 56, 1, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1, 4, 0, 0, 0, '0);
        chk_outs("tbl_reset", 56, 1, 0, 1, 0);
        drive(1, 1, 0, 0, 0, '0);
        chk_outs("refetch1", 1, 0, 0, 0, 0);
        drive(1, 1, 0, 0, 0, '0);
        drive(1, 1, 0, 0, 0, '0);
        chk_outs("refetch3", 3, 0, 1, 0, 0);

        // Halt is sticky regardless of start, ir_out or config writes.
        drive(1, 57, 0, 0, 0, '0);
        chk_outs("halt", 56, 0, 0, 0, 1);
        for (int i = 0; i < 10; i++) begin
            drive(i[0], (i[1] ? 1 : 4), i[2], i[0], 1, mk(0,0,0,2,9));
            chk_outs($sformatf("halt_hold%0d", i), 56, 0, 0, 0, 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not reach its summary, expected completion");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
